// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle control unit.
//   state_e      - FSM state encodings (also driven out on the debug port)
//   OP_*         - instruction opcodes, instr[31:26]
//   PC_*         - pc_src select codes
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000101;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory wait-state counter with timeout.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - return the counter to 0 (priority over count)
//   count      - a request is stalled this cycle; increment
//   timeout    - stalled cycle with the counter at WAIT_MAX-1 (never when WAIT_MAX=0)
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam int unsigned   CW   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (WAIT_MAX != 0) && count && (cnt_q == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control unit (IF/ID/EX/MEM/WB) for a single-ALU datapath.
//   clk, reset          - clock, asynchronous active-low reset (all outputs 0 while low)
//   instr               - IR contents, opcode in [31:26]
//   mem_ready, alu_zero - memory handshake, ALU zero flag
//   ir_we, pc_we, pc_src, alu_en, alu_src_imm, mem_req, mem_we,
//   rf_we, rf_wsel, rf_dst_rt - datapath enables/selects
//   state, illegal, bus_err   - debug state, undefined-opcode and timeout pulses
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt / retire_cnt outputs.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned IW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr,
    input  logic          mem_ready,
    input  logic          alu_zero,
    output logic          ir_we,
    output logic          pc_we,
    output logic [1:0]    pc_src,
    output logic          alu_en,
    output logic          alu_src_imm,
    output logic          mem_req,
    output logic          mem_we,
    output logic          rf_we,
    output logic          rf_wsel,
    output logic          rf_dst_rt,
    output logic [2:0]    state,
    output logic          illegal,
    output logic          bus_err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]   cycle_cnt,
    output logic [31:0]   retire_cnt
`endif
);

    state_e     state_d, state_q;
    // abort_q marks the single idle cycle (shown as IF, no request) after a timeout
    logic       abort_d, abort_q;
    logic       stall, timeout, retire;
    logic [5:0] opcode;

    assign opcode = instr[31:26];

    // Only the opcode is decoded here; the remaining fields feed the datapath.
    logic instr_unused;
    assign instr_unused = ^instr;

    // Kept out of the main decode block so the timer's timeout has no path back into it.
    assign mem_req = reset && !abort_q && (state_q == ST_IF || state_q == ST_MEM);
    assign stall   = mem_req && !mem_ready;

    // Counter is nonzero only during an ongoing stall, which matches clearing on
    // every entry to IF/MEM.
    mc_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (!stall || timeout),
        .count  (stall),
        .timeout(timeout)
    );

    always_comb begin
        state_d     = state_q;
        abort_d     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_INC;
        alu_en      = 1'b0;
        alu_src_imm = 1'b0;
        mem_we      = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 1'b0;
        rf_dst_rt   = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        retire      = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IF: begin
                    if (abort_q) begin
                        state_d = ST_IF;
                    end else if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_src  = PC_INC;
                        state_d = ST_ID;
                    end else if (timeout) begin
                        bus_err = 1'b1;
                        abort_d = 1'b1;
                    end
                end
                ST_ID: begin
                    case (opcode)
                        OP_NOP: begin
                            retire  = 1'b1;
                            state_d = ST_IF;
                        end
                        OP_J: begin
                            pc_we   = 1'b1;
                            pc_src  = PC_JMP;
                            retire  = 1'b1;
                            state_d = ST_IF;
                        end
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_d = ST_EX;
                        default: begin
                            illegal = 1'b1;
                            state_d = ST_IF;
                        end
                    endcase
                end
                ST_EX: begin
                    alu_en = 1'b1;
                    case (opcode)
                        OP_RTYPE: state_d = ST_WB;
                        OP_LW, OP_SW: begin
                            alu_src_imm = 1'b1;
                            state_d     = ST_MEM;
                        end
                        OP_BEQ: begin
                            if (alu_zero) begin
                                pc_we  = 1'b1;
                                pc_src = PC_BR;
                            end
                            retire  = 1'b1;
                            state_d = ST_IF;
                        end
                        default: state_d = ST_IF;
                    endcase
                end
                ST_MEM: begin
                    mem_we = (opcode == OP_SW);
                    if (mem_ready) begin
                        if (opcode == OP_SW) begin
                            retire  = 1'b1;
                            state_d = ST_IF;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (timeout) begin
                        bus_err = 1'b1;
                        abort_d = 1'b1;
                        state_d = ST_IF;
                    end
                end
                ST_WB: begin
                    rf_we     = 1'b1;
                    rf_wsel   = (opcode == OP_LW);
                    rf_dst_rt = (opcode == OP_LW);
                    retire    = 1'b1;
                    state_d   = ST_IF;
                end
                default: state_d = ST_IF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    assign state = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_d, cycle_cnt_q;
    logic [31:0] retire_cnt_d, retire_cnt_q;

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q + 32'd1;
        retire_cnt_d = retire_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    logic retire_unused;
    assign retire_unused = retire;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed, table-driven bench for mc_ctrl_fsm (WAIT_MAX=16, default build).
module tb_mc_ctrl_fsm;

    // Expected-output bit positions in the 13-bit packed vector
    // {ir_we, pc_we, pc_src[1:0], alu_en, alu_src_imm, mem_req, mem_we,
    //  rf_we, rf_wsel, rf_dst_rt, illegal, bus_err}
    localparam logic [12:0] IRW = 13'h1000;
    localparam logic [12:0] PCW = 13'h0800;
    localparam logic [12:0] PJ  = 13'h0400;
    localparam logic [12:0] PBR = 13'h0200;
    localparam logic [12:0] ALU = 13'h0100;
    localparam logic [12:0] IMM = 13'h0080;
    localparam logic [12:0] MRQ = 13'h0040;
    localparam logic [12:0] MWE = 13'h0020;
    localparam logic [12:0] RFW = 13'h0010;
    localparam logic [12:0] WSL = 13'h0008;
    localparam logic [12:0] DRT = 13'h0004;
    localparam logic [12:0] ILL = 13'h0002;
    localparam logic [12:0] BER = 13'h0001;
    localparam logic [12:0] FETCH = IRW | PCW | MRQ;

    localparam logic [31:0] I_RT  = 32'h04224002;
    localparam logic [31:0] I_LW  = 32'h0821000A;
    localparam logic [31:0] I_SW  = 32'h0C220004;
    localparam logic [31:0] I_BEQ = 32'h10220003;
    localparam logic [31:0] I_J   = 32'h14000001;
    localparam logic [31:0] I_BAD = 32'hFC000000;
    localparam logic [31:0] I_NOP = 32'h00000000;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        ir_we, pc_we, alu_en, alu_src_imm, mem_req, mem_we;
    logic        rf_we, rf_wsel, rf_dst_rt, illegal, bus_err;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [12:0] outs;

    int checks   = 0;
    int failures = 0;

    mc_ctrl_fsm #(
        .WAIT_MAX(16),
        .IW(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_en     (alu_en),
        .alu_src_imm(alu_src_imm),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .rf_dst_rt  (rf_dst_rt),
        .state      (state),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    assign outs = {ir_we, pc_we, pc_src, alu_en, alu_src_imm, mem_req, mem_we,
                   rf_we, rf_wsel, rf_dst_rt, illegal, bus_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic        az;
        logic [2:0]  st;
        logic [12:0] outs;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [31:0] i, input logic mr, input logic az,
                       input logic [2:0] st, input logic [12:0] o);
        vec_t v;
        v.instr = i; v.mr = mr; v.az = az; v.st = st; v.outs = o;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] est, input logic [12:0] eo);
        checks++;
        if (state !== est || outs !== eo) begin
            failures++;
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     name, state, outs, est, eo);
        end
    endtask

    // One clock cycle: drive, settle, compare well before the rising edge, advance.
    task automatic cyc(input string name, input logic [31:0] i, input logic mr,
                       input logic az, input logic [2:0] est, input logic [12:0] eo);
        instr = i; mem_ready = mr; alu_zero = az;
        #2;
        check(name, est, eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // RTYPE, zero wait: IF, ID, EX, WB (alu_zero and mem_ready ignored outside EX/IF/MEM)
        add(I_RT, 1, 0, 0, FETCH);
        add(I_RT, 1, 1, 1, 0);
        add(I_RT, 1, 1, 2, ALU);
        add(I_RT, 1, 1, 4, RFW);
        // LW with 3 wait states in MEM
        add(I_LW, 1, 0, 0, FETCH);
        add(I_LW, 1, 0, 1, 0);
        add(I_LW, 1, 0, 2, ALU | IMM);
        add(I_LW, 0, 0, 3, MRQ);
        add(I_LW, 0, 0, 3, MRQ);
        add(I_LW, 0, 0, 3, MRQ);
        add(I_LW, 1, 0, 3, MRQ);
        add(I_LW, 1, 0, 4, RFW | WSL | DRT);
        // BEQ taken
        add(I_BEQ, 1, 1, 0, FETCH);
        add(I_BEQ, 1, 1, 1, 0);
        add(I_BEQ, 1, 1, 2, ALU | PCW | PBR);
        // BEQ not taken
        add(I_BEQ, 1, 0, 0, FETCH);
        add(I_BEQ, 1, 0, 1, 0);
        add(I_BEQ, 1, 0, 2, ALU);
        // J
        add(I_J, 1, 0, 0, FETCH);
        add(I_J, 1, 1, 1, PCW | PJ);
        // Illegal opcode
        add(I_BAD, 1, 0, 0, FETCH);
        add(I_BAD, 1, 0, 1, ILL);
        // SW, zero wait
        add(I_SW, 1, 0, 0, FETCH);
        add(I_SW, 1, 0, 1, 0);
        add(I_SW, 1, 0, 2, ALU | IMM);
        add(I_SW, 1, 0, 3, MRQ | MWE);
        // NOP
        add(I_NOP, 1, 0, 0, FETCH);
        add(I_NOP, 1, 0, 1, 0);
        // IF with one wait state, then NOP
        add(I_NOP, 0, 0, 0, MRQ);
        add(I_NOP, 1, 0, 0, FETCH);
        add(I_NOP, 1, 0, 1, 0);

        reset = 1'b0; instr = I_NOP; mem_ready = 1'b1; alu_zero = 1'b1;
        #2;
        check("reset_state", 3'd0, 13'h0);
        #8;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].instr, tbl[i].mr, tbl[i].az,
                tbl[i].st, tbl[i].outs);
        end

        // Fetch timeout: bus_err on the 16th request cycle, one idle cycle, re-fetch.
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("if_stall%0d", i), I_NOP, 0, 0, 0, MRQ);
        end
        cyc("if_timeout", I_NOP, 0, 0, 0, MRQ | BER);
        cyc("if_idle", I_NOP, 0, 0, 0, 0);
        cyc("if_refetch", I_NOP, 1, 0, 0, FETCH);
        cyc("if_refetch_id", I_NOP, 1, 0, 1, 0);

        // Data timeout in MEM: instruction discarded, no write-back.
        cyc("mt_if", I_LW, 1, 0, 0, FETCH);
        cyc("mt_id", I_LW, 1, 0, 1, 0);
        cyc("mt_ex", I_LW, 1, 0, 2, ALU | IMM);
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("mem_stall%0d", i), I_LW, 0, 0, 3, MRQ);
        end
        cyc("mem_timeout", I_LW, 0, 0, 3, MRQ | BER);
        cyc("mem_idle", I_LW, 0, 0, 0, 0);
        cyc("mem_refetch", I_LW, 0, 0, 0, MRQ);

        // mem_ready arriving on the timeout cycle completes normally.
        cyc("race_if", I_LW, 1, 0, 0, FETCH);
        cyc("race_id", I_LW, 1, 0, 1, 0);
        cyc("race_ex", I_LW, 1, 0, 2, ALU | IMM);
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("race_stall%0d", i), I_LW, 0, 0, 3, MRQ);
        end
        cyc("race_ready", I_LW, 1, 0, 3, MRQ);
        cyc("race_wb", I_LW, 1, 0, 4, RFW | WSL | DRT);

        // Asynchronous reset in the middle of a SW in MEM.
        cyc("ar_if", I_SW, 1, 0, 0, FETCH);
        cyc("ar_id", I_SW, 1, 0, 1, 0);
        cyc("ar_ex", I_SW, 1, 0, 2, ALU | IMM);
        instr = I_SW; mem_ready = 1'b0; alu_zero = 1'b0;
        #2;
        check("ar_mem", 3'd3, MRQ | MWE);
        #1;
        reset = 1'b0;
        #1;
        check("ar_async", 3'd0, 13'h0);
        @(posedge clk);
        #1;
        check("ar_held", 3'd0, 13'h0);
        reset = 1'b1;
        cyc("ar_first_req", I_NOP, 0, 0, 0, MRQ);
        cyc("ar_fetch", I_NOP, 1, 0, 0, FETCH);
        cyc("ar_id_nop", I_NOP, 1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
